// File: rtl/ddr_readback_256_if.sv
// Avalon-MM read channel plus the unpacked 32-bit lane stream of ddr_readback_256.
// master = the readback engine, slave = the memory/consumer side.
interface ddr_readback_256_if #(
    parameter int LANES = 8
);
    logic [24:0]         amm_addr;
    logic                amm_read;
    logic [6:0]          amm_burstcount;
    logic [32*LANES-1:0] amm_byteenable;
    logic                amm_ready;
    logic [32*LANES-1:0] amm_readdata;
    logic                amm_readdatavalid;

    logic [31:0]         dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                dout_last;

    modport master (
        output amm_addr, amm_read, amm_burstcount, amm_byteenable,
        input  amm_ready, amm_readdata, amm_readdatavalid,
        output dout, dout_valid, dout_last,
        input  dout_ready
    );

    modport slave (
        input  amm_addr, amm_read, amm_burstcount, amm_byteenable,
        output amm_ready, amm_readdata, amm_readdatavalid,
        input  dout, dout_valid, dout_last,
        output dout_ready
    );
endinterface

// File: rtl/ddr_readback_256.sv
// Avalon-MM read master: fetches word_count 256-bit words from base_addr and
// streams them out as 32-bit lanes, lane 0 (bits 31:0) first.
module ddr_readback_256 #(
    parameter int FIFO_DEPTH = 4,
    parameter int LANES      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [24:0] base_addr,
    input  logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    ddr_readback_256_if.master bus
);
    localparam int DATA_W = 32 * LANES;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [24:0]       base_q, base_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       issued_q, issued_d;
    logic [15:0]       words_q, words_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [CNT_W-1:0]  in_flight_q, in_flight_d;
    logic [CNT_W-1:0]  used_q, used_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [31:0]       lane_word [LANES];

    logic              in_run;
    logic [CNT_W:0]    outstanding;
    logic              credit_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              lane_hs;
    logic              lane_is_last;
    logic              word_is_final;
    logic              final_hs;

    // The FIFO head is the word being unpacked; it is freed only after its last lane leaves.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_word[gi] = fifo_mem[rd_ptr_q][32*gi +: 32];
        end
    endgenerate

    assign in_run        = (state_q == S_RUN);
    assign outstanding   = {1'b0, in_flight_q} + {1'b0, used_q};
    assign credit_ok     = (outstanding < (CNT_W+1)'(FIFO_DEPTH));
    assign lane_is_last  = (lane_q == LANE_W'(LANES - 1));
    assign word_is_final = (words_q == count_q - 16'd1);

    assign bus.amm_read       = in_run && (issued_q < count_q) && credit_ok;
    assign bus.amm_addr       = base_q + 25'(issued_q);
    assign bus.amm_burstcount = 7'd1;
    assign bus.amm_byteenable = '1;
    assign bus.dout_valid     = in_run && (used_q != '0);
    assign bus.dout           = bus.dout_valid ? lane_word[lane_q] : 32'd0;
    assign bus.dout_last      = bus.dout_valid && lane_is_last && word_is_final;

    // Returns outside a run, or with nothing outstanding, are stale and dropped.
    assign accept   = bus.amm_read && bus.amm_ready;
    assign push     = in_run && bus.amm_readdatavalid && (in_flight_q != '0);
    assign lane_hs  = bus.dout_valid && bus.dout_ready;
    assign pop      = lane_hs && lane_is_last;
    assign final_hs = pop && word_is_final;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        issued_d    = issued_q;
        words_d     = words_q;
        lane_d      = lane_q;
        in_flight_d = in_flight_q;
        used_d      = used_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        done_d      = (state_q == S_FIN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    count_d     = word_count;
                    issued_d    = '0;
                    words_d     = '0;
                    lane_d      = '0;
                    in_flight_d = '0;
                    used_d      = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    state_d     = (word_count == 16'd0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                issued_d    = issued_q + 16'(accept);
                in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(push);
                used_d      = used_q + CNT_W'(push) - CNT_W'(pop);
                wr_ptr_d    = wr_ptr_q + PTR_W'(push);
                rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
                if (lane_hs) begin
                    lane_d = lane_is_last ? '0 : lane_q + LANE_W'(1);
                end
                if (pop) begin
                    words_d = words_q + 16'd1;
                end
                if (final_hs) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            words_q     <= '0;
            lane_q      <= '0;
            in_flight_q <= '0;
            used_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            words_q     <= words_d;
            lane_q      <= lane_d;
            in_flight_q <= in_flight_d;
            used_q      <= used_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.amm_readdata;
        end
    end
endmodule
